ball_motion: RTL and testbench
==============================

Name: ball_motion

Overview:
Per-ball kinematics stage directly downstream of the collision/hole hit controller; one instance per ball (white, red).
- Holds the ball's fixed-point position and velocity.
- Accepts cue shots, latches collision velocities and hole hits reported during the pixel scan, and applies them once per frame.
- Integrates position, applies friction, and feeds topLeft position/velocity back to the drawers and to the hit controller.

Parameters:
INIT_X, 100, top-left X pixel after reset/respawn
INIT_Y, 200, top-left Y pixel after reset/respawn
FRAC_BITS, 6, fractional bits of position; velocity unit = 1/2^FRAC_BITS px/frame
MAX_X, 623, largest legal top-left X pixel (clamp)
MAX_Y, 463, largest legal top-left Y pixel (clamp)
FRICTION_PERIOD, 4, frames between friction decrements (>=1)
FRICTION_STEP, 1, velocity magnitude removed per axis per friction event

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-cycle pulse at frame start
shotValid  in  1  cue shot request
shotVelX  in  11 signed  shot velocity X
shotVelY  in  11 signed  shot velocity Y
shotReady  out  1  shot accepted this cycle if shotValid
collisionOccurred  in  1  collision flag from hit controller
colVelX  in  11 signed  post-collision velocity X
colVelY  in  11 signed  post-collision velocity Y
holeHit  in  1  ball over a hole
holeNum  in  3  hole index
respawn  in  1  re-place sunk ball
topLeftX  out  11  integer position X
topLeftY  out  11  integer position Y
velX  out  11 signed  current velocity X
velY  out  11 signed  current velocity Y
moving  out  1  ball has nonzero velocity
sunk  out  1  ball is in a hole
sunkHoleNum  out  3  latched hole index
sunkPulse  out  1  one-cycle pulse on entering SUNK

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, resetN.
- Reset values:
  - position = INIT << FRAC_BITS; velocity 0.
  - state IDLE; colPending 0; friction counter 0.
  - outputs: topLeftX=INIT_X, topLeftY=INIT_Y, vel 0, moving 0, sunk 0, sunkHoleNum 0, sunkPulse 0.
  - shotReady=1 (IDLE with no collision pending).
- Internal position: unsigned (11+FRAC_BITS) bits. topLeft = pos >> FRAC_BITS, registered.
- States: IDLE, MOVING, UPDATE_POS, SUNK.
- Collision latch:
  - In IDLE/MOVING/UPDATE_POS, the first collisionOccurred after the last frame update sets colPending and captures colVelX/Y.
  - Later collisions in the same frame are ignored.
- Shot:
  - shotReady = (state==IDLE) && !colPending.
  - Accepted shot loads velocity immediately. If nonzero, state goes to MOVING; if both components are 0, state stays IDLE.
- startOfFrame in IDLE or MOVING:
  - Velocity update first. If colPending, vel <= captured colVel and colPending is cleared. Otherwise, in MOVING, apply friction when frictionCnt==FRICTION_PERIOD-1.
  - frictionCnt wraps modulo FRICTION_PERIOD; it increments only in MOVING and resets to 0 on entry to MOVING.
  - Friction per axis: if |v|<=FRICTION_STEP then v=0, else v -= sign(v)*FRICTION_STEP.
  - Next state is UPDATE_POS.
- UPDATE_POS (exactly 1 cycle):
  - pos += sign-extended vel, computed with one extra sign bit.
  - Clamp to [0, MAX<<FRAC_BITS] per axis. Clamping does not alter velocity (bounce is the hit controller's job).
  - Next state is MOVING if vel!=0, else IDLE.
  - topLeft outputs change 2 cycles after startOfFrame.
- Hole:
  - holeHit in any non-SUNK state has highest priority over shot, collision and frame update.
  - Next cycle: state SUNK, vel 0, colPending 0, sunkHoleNum <= holeNum, sunkPulse=1 for one cycle.
- SUNK:
  - Position frozen; sunk=1; shot, collision, holeHit and startOfFrame are ignored.
  - respawn: pos <= INIT, vel 0, state IDLE, sunk 0. respawn is ignored in other states.
- moving = (velX!=0)||(velY!=0).
- Simultaneous events:
  - shotValid and collisionOccurred in the same IDLE cycle: the collision is latched and the shot is accepted. The shot sets velocity now; the collision velocity overwrites it at the next startOfFrame.
  - startOfFrame and collisionOccurred in the same cycle: the collision is latched for the following frame.
- resetN asserted mid-operation (any state): all registers return to reset values immediately.

Decomposition:
- Shared package ball_pkg:
  - typedef vel_t (logic signed [10:0]).
  - motion state enum.
  - FRAC_BITS default and screen-limit constants, reused by the hit controller's instantiation.
- One natural sub-module: ball_friction. Combinational per-axis friction function, instanced twice (X, Y).

Test Plan:
- Reset: hold resetN=0 -> topLeft=(100,200), vel 0, shotReady=1, sunk=0; release -> values unchanged.
- Shot: velX=128, velY=0 in IDLE; one startOfFrame -> topLeftX=102 two cycles later. After 4 frames velX=127 (friction), topLeftX=107.
- Friction to rest: shot velX=1 -> after 4 frames velX=0, moving=0, state IDLE, shotReady=1.
- Collisions in one frame: two collisionOccurred pulses with colVelX=-64 then +300 before startOfFrame -> velX=-64 applied; topLeftX decrements by 1 that frame.
- Clamp: ball at X=622, velX=+192 -> topLeftX=623; velX stays 192 (no clamp-induced change).
- Hole: holeHit=1 with holeNum=5 and collision in the same cycle -> sunk=1, sunkPulse one cycle, sunkHoleNum=5, vel 0; shots ignored; respawn -> (100,200), IDLE.

Source files
------------

// File: rtl/ball_pkg.sv
// ball_pkg: shared types and screen constants for ball kinematics and the hit controller
package ball_pkg;
    typedef logic signed [10:0] vel_t;
    typedef enum logic [1:0] {ST_IDLE, ST_MOVING, ST_UPDATE_POS, ST_SUNK} motion_state_t;
    localparam int BALL_FRAC_BITS = 6;
    localparam int SCREEN_MAX_X   = 623;
    localparam int SCREEN_MAX_Y   = 463;
endpackage

// File: rtl/ball_friction.sv
// ball_friction: removes STEP from the velocity magnitude, stopping at zero
module ball_friction
    import ball_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic signed [10:0] vel_in,
    output logic signed [10:0] vel_out
);
    logic signed [11:0] wide;
    logic signed [11:0] mag;
    // widened so |-1024| does not overflow
    always_comb begin
        wide    = 12'(vel_in);
        mag     = wide < 0 ? -wide : wide;
        vel_out = mag <= 12'(STEP) ? '0 : (wide < 0 ? vel_t'(wide + 12'(STEP)) : vel_t'(wide - 12'(STEP)));
    end
endmodule

// File: rtl/ball_motion.sv
// ball_motion: per-ball position/velocity integration with shots, collisions, friction and holes
module ball_motion
    import ball_pkg::*;
#(
    parameter int INIT_X          = 100,
    parameter int INIT_Y          = 200,
    parameter int FRAC_BITS       = BALL_FRAC_BITS,
    parameter int MAX_X           = SCREEN_MAX_X,
    parameter int MAX_Y           = SCREEN_MAX_Y,
    parameter int FRICTION_PERIOD = 4,
    parameter int FRICTION_STEP   = 1
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               shotValid,
    input  logic signed [10:0] shotVelX,
    input  logic signed [10:0] shotVelY,
    output logic               shotReady,
    input  logic               collisionOccurred,
    input  logic signed [10:0] colVelX,
    input  logic signed [10:0] colVelY,
    input  logic               holeHit,
    input  logic [2:0]         holeNum,
    input  logic               respawn,
    output logic [10:0]        topLeftX,
    output logic [10:0]        topLeftY,
    output logic signed [10:0] velX,
    output logic signed [10:0] velY,
    output logic               moving,
    output logic               sunk,
    output logic [2:0]         sunkHoleNum,
    output logic               sunkPulse
);
    localparam int W  = 11 + FRAC_BITS;
    localparam int CW = FRICTION_PERIOD > 1 ? $clog2(FRICTION_PERIOD) : 1;
    localparam logic [W-1:0]  INIT_PX = W'(INIT_X * (2 ** FRAC_BITS));
    localparam logic [W-1:0]  INIT_PY = W'(INIT_Y * (2 ** FRAC_BITS));
    localparam logic [W-1:0]  MAX_PX  = W'(MAX_X * (2 ** FRAC_BITS));
    localparam logic [W-1:0]  MAX_PY  = W'(MAX_Y * (2 ** FRAC_BITS));
    localparam logic [CW-1:0] CNT_TOP = CW'(FRICTION_PERIOD - 1);

    motion_state_t state_q, state_d;
    logic [W-1:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    vel_t          vel_x_q, vel_x_d, vel_y_q, vel_y_d;
    vel_t          col_vel_x_q, col_vel_x_d, col_vel_y_q, col_vel_y_d;
    logic          col_pending_q, col_pending_d;
    logic [CW-1:0] fric_cnt_q, fric_cnt_d;
    logic [10:0]   top_left_x_q, top_left_x_d, top_left_y_q, top_left_y_d;
    logic [2:0]    sunk_hole_q, sunk_hole_d;
    logic          sunk_pulse_q, sunk_pulse_d;
    vel_t          fric_x, fric_y;
    logic          frame, shot_ok;

    ball_friction #(.STEP(FRICTION_STEP)) u_fric_x (.vel_in(vel_x_q), .vel_out(fric_x));
    ball_friction #(.STEP(FRICTION_STEP)) u_fric_y (.vel_in(vel_y_q), .vel_out(fric_y));

    function automatic logic [W-1:0] step_pos(input logic [W-1:0] p, input vel_t v, input logic [W-1:0] lim);
        logic signed [W+1:0] s;
        s = $signed({2'b00, p}) + (W+2)'(v);
        return s < 0 ? '0 : (s > $signed({2'b00, lim}) ? lim : s[W-1:0]);
    endfunction

    assign shotReady   = state_q == ST_IDLE && !col_pending_q;
    assign shot_ok     = shotValid && shotReady;
    assign frame       = startOfFrame && (state_q == ST_IDLE || state_q == ST_MOVING);
    assign topLeftX    = top_left_x_q;
    assign topLeftY    = top_left_y_q;
    assign velX        = vel_x_q;
    assign velY        = vel_y_q;
    assign moving      = vel_x_q != 0 || vel_y_q != 0;
    assign sunk        = state_q == ST_SUNK;
    assign sunkHoleNum = sunk_hole_q;
    assign sunkPulse   = sunk_pulse_q;

    // next-state: hole beats everything; frame update applies latched collision or friction
    always_comb begin
        state_d       = state_q;
        pos_x_d       = pos_x_q;
        pos_y_d       = pos_y_q;
        vel_x_d       = vel_x_q;
        vel_y_d       = vel_y_q;
        col_vel_x_d   = col_vel_x_q;
        col_vel_y_d   = col_vel_y_q;
        col_pending_d = col_pending_q;
        fric_cnt_d    = fric_cnt_q;
        sunk_hole_d   = sunk_hole_q;
        sunk_pulse_d  = 1'b0;
        if (state_q == ST_SUNK) begin
            if (respawn) begin
                pos_x_d = INIT_PX;
                pos_y_d = INIT_PY;
                vel_x_d = '0;
                vel_y_d = '0;
                state_d = ST_IDLE;
            end
        end else if (holeHit) begin
            state_d       = ST_SUNK;
            vel_x_d       = '0;
            vel_y_d       = '0;
            col_pending_d = 1'b0;
            fric_cnt_d    = '0;
            sunk_hole_d   = holeNum;
            sunk_pulse_d  = 1'b1;
        end else begin
            if (frame) begin
                if (col_pending_q) begin
                    vel_x_d       = col_vel_x_q;
                    vel_y_d       = col_vel_y_q;
                    col_pending_d = 1'b0;
                end else if (state_q == ST_MOVING && fric_cnt_q == CNT_TOP) begin
                    vel_x_d = fric_x;
                    vel_y_d = fric_y;
                end else if (shot_ok) begin
                    vel_x_d = shotVelX;
                    vel_y_d = shotVelY;
                end
                fric_cnt_d = state_q == ST_MOVING ? (fric_cnt_q == CNT_TOP ? '0 : fric_cnt_q + 1'b1) : '0;
                state_d    = ST_UPDATE_POS;
            end else if (shot_ok) begin
                vel_x_d    = shotVelX;
                vel_y_d    = shotVelY;
                fric_cnt_d = '0;
                state_d    = (shotVelX != 0 || shotVelY != 0) ? ST_MOVING : ST_IDLE;
            end else if (state_q == ST_UPDATE_POS) begin
                pos_x_d = step_pos(pos_x_q, vel_x_q, MAX_PX);
                pos_y_d = step_pos(pos_y_q, vel_y_q, MAX_PY);
                state_d = (vel_x_q != 0 || vel_y_q != 0) ? ST_MOVING : ST_IDLE;
            end
            if (collisionOccurred && (!col_pending_q || frame)) begin
                col_pending_d = 1'b1;
                col_vel_x_d   = colVelX;
                col_vel_y_d   = colVelY;
            end
        end
        top_left_x_d = pos_x_d[W-1:FRAC_BITS];
        top_left_y_d = pos_y_d[W-1:FRAC_BITS];
    end

    // state registers with asynchronous reset to the spawn point
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= ST_IDLE;
            pos_x_q       <= INIT_PX;
            pos_y_q       <= INIT_PY;
            vel_x_q       <= '0;
            vel_y_q       <= '0;
            col_vel_x_q   <= '0;
            col_vel_y_q   <= '0;
            col_pending_q <= 1'b0;
            fric_cnt_q    <= '0;
            top_left_x_q  <= 11'(INIT_X);
            top_left_y_q  <= 11'(INIT_Y);
            sunk_hole_q   <= '0;
            sunk_pulse_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            vel_x_q       <= vel_x_d;
            vel_y_q       <= vel_y_d;
            col_vel_x_q   <= col_vel_x_d;
            col_vel_y_q   <= col_vel_y_d;
            col_pending_q <= col_pending_d;
            fric_cnt_q    <= fric_cnt_d;
            top_left_x_q  <= top_left_x_d;
            top_left_y_q  <= top_left_y_d;
            sunk_hole_q   <= sunk_hole_d;
            sunk_pulse_q  <= sunk_pulse_d;
        end
    end
endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: directed checks of ball_motion with a second instance spawned near the right edge
module tb_ball_motion;
    logic               clk = 1'b0;
    logic               resetN;
    logic               startOfFrame, shotValid, collisionOccurred, holeHit, respawn;
    logic signed [10:0] shotVelX, shotVelY, colVelX, colVelY;
    logic [2:0]         holeNum;
    logic               shotReady, moving, sunk, sunkPulse;
    logic [10:0]        topLeftX, topLeftY;
    logic signed [10:0] velX, velY;
    logic [2:0]         sunkHoleNum;
    logic               e_shotReady, e_moving, e_sunk, e_sunkPulse;
    logic [10:0]        e_topLeftX, e_topLeftY;
    logic signed [10:0] e_velX, e_velY;
    logic [2:0]         e_sunkHoleNum;
    int                 n_assert = 0;
    int                 n_fail   = 0;

    always #5 clk = ~clk;

    ball_motion dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .shotValid(shotValid), .shotVelX(shotVelX), .shotVelY(shotVelY), .shotReady(shotReady),
        .collisionOccurred(collisionOccurred), .colVelX(colVelX), .colVelY(colVelY),
        .holeHit(holeHit), .holeNum(holeNum), .respawn(respawn),
        .topLeftX(topLeftX), .topLeftY(topLeftY), .velX(velX), .velY(velY),
        .moving(moving), .sunk(sunk), .sunkHoleNum(sunkHoleNum), .sunkPulse(sunkPulse)
    );

    ball_motion #(.INIT_X(622)) dut_edge (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .shotValid(shotValid), .shotVelX(shotVelX), .shotVelY(shotVelY), .shotReady(e_shotReady),
        .collisionOccurred(collisionOccurred), .colVelX(colVelX), .colVelY(colVelY),
        .holeHit(holeHit), .holeNum(holeNum), .respawn(respawn),
        .topLeftX(e_topLeftX), .topLeftY(e_topLeftY), .velX(e_velX), .velY(e_velY),
        .moving(e_moving), .sunk(e_sunk), .sunkHoleNum(e_sunkHoleNum), .sunkPulse(e_sunkPulse)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
        tick();
    endtask

    task automatic shoot(input int vx, input int vy);
        shotValid = 1'b1;
        shotVelX  = 11'(vx);
        shotVelY  = 11'(vy);
        tick();
        shotValid = 1'b0;
    endtask

    task automatic sink_and_respawn(input logic [2:0] hole);
        holeHit = 1'b1;
        holeNum = hole;
        tick();
        holeHit = 1'b0;
        chk("hole_sunk", sunk, 1);
        chk("hole_num", sunkHoleNum, hole);
        respawn = 1'b1;
        tick();
        respawn = 1'b0;
        chk("respawn_x", topLeftX, 100);
    endtask

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; shotValid = 1'b0; collisionOccurred = 1'b0;
        holeHit = 1'b0; respawn = 1'b0; holeNum = '0;
        shotVelX = '0; shotVelY = '0; colVelX = '0; colVelY = '0;
        #12;
        chk("rst_x", topLeftX, 100);
        chk("rst_y", topLeftY, 200);
        chk("rst_velx", velX, 0);
        chk("rst_ready", shotReady, 1);
        chk("rst_sunk", sunk, 0);
        chk("rst_moving", moving, 0);
        chk("rst_pulse", sunkPulse, 0);
        chk("rst_holenum", sunkHoleNum, 0);
        resetN = 1'b1;
        tick();
        chk("rel_x", topLeftX, 100);
        chk("rel_y", topLeftY, 200);
        chk("rel_ready", shotReady, 1);

        shoot(192, 0);
        chk("shot_velx", velX, 192);
        chk("shot_moving", moving, 1);
        chk("shot_ready_low", shotReady, 0);
        frame();
        chk("clamp_x", e_topLeftX, 623);
        chk("clamp_velx", e_velX, 192);
        chk("free_x", topLeftX, 103);

        holeHit = 1'b1; holeNum = 3'd5; collisionOccurred = 1'b1; colVelX = 11'sd50;
        tick();
        holeHit = 1'b0; collisionOccurred = 1'b0;
        chk("sunk", sunk, 1);
        chk("sunk_pulse", sunkPulse, 1);
        chk("sunk_num", sunkHoleNum, 5);
        chk("sunk_velx", velX, 0);
        tick();
        chk("sunk_pulse_drop", sunkPulse, 0);
        chk("sunk_ready", shotReady, 0);
        shoot(100, 0);
        chk("sunk_shot_ignored", velX, 0);
        frame();
        chk("sunk_frozen_x", topLeftX, 103);
        respawn = 1'b1;
        tick();
        respawn = 1'b0;
        chk("respawn_x", topLeftX, 100);
        chk("respawn_y", topLeftY, 200);
        chk("respawn_sunk", sunk, 0);
        chk("respawn_ready", shotReady, 1);
        chk("respawn_edge_x", e_topLeftX, 622);

        shoot(128, -64);
        frame();
        chk("f1_x", topLeftX, 102);
        chk("f1_y", topLeftY, 199);
        frame();
        frame();
        frame();
        chk("f4_velx", velX, 127);
        chk("f4_vely", velY, -63);
        chk("f4_x", topLeftX, 107);
        chk("f4_y", topLeftY, 196);
        sink_and_respawn(3'd2);

        shoot(1, 0);
        frame();
        frame();
        frame();
        chk("f3_velx_min", velX, 1);
        frame();
        chk("rest_velx", velX, 0);
        chk("rest_moving", moving, 0);
        chk("rest_ready", shotReady, 1);
        chk("rest_x", topLeftX, 100);

        collisionOccurred = 1'b1; colVelX = -11'sd64; colVelY = '0;
        tick();
        colVelX = 11'sd300;
        tick();
        collisionOccurred = 1'b0;
        chk("col_pending_ready", shotReady, 0);
        chk("col_not_applied", velX, 0);
        frame();
        chk("col_velx", velX, -64);
        chk("col_x", topLeftX, 99);

        resetN = 1'b0;
        #2;
        chk("midrst_x", topLeftX, 100);
        chk("midrst_velx", velX, 0);
        chk("midrst_ready", shotReady, 1);
        resetN = 1'b1;
        tick();
        chk("midrst_moving", moving, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
